// File: rtl/memout_rd_sched_pkg.sv
// Shared types and helpers for the memory-out read scheduler.
// Phase-count derivation, FSM states and latency-pipe payload.
package memOut_port_pkg;

   localparam int PH_MAX_W = 16;

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } state_t;

   typedef struct packed {
      logic                valid;
      logic                last;
      logic [PH_MAX_W-1:0] ph;
   } lat_pl_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int phase_num(input int v, input int r);
      return ceil_div(v, r);
   endfunction

   function automatic int phase_w(input int v, input int r);
      int n;
      n = phase_num(v, r);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/memout_rd_sched_lat_pipe.sv
// Fixed-depth delay line for the phase payload.
// Matches the memory read latency so controls line up with data.
module memOut_lat_pipe
   import memOut_port_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    sys_clk,
   input  logic    rstn,
   input  lat_pl_t d,
   output lat_pl_t q
);

   lat_pl_t [DEPTH-1:0] sr;

   // Shift the payload one stage per cycle; reset clears all stages.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/memout_rd_sched.sv
// Serialises one V-port read request onto R physical ports.
// Emits phase/valid/done aligned with returning read data.
module memout_rd_sched
   import memOut_port_pkg::*;
#(
   parameter int REAL_PORT_NUM    = 1,
   parameter int VIRTUAL_PORT_NUM = 2,
   parameter int ADDR_WIDTH       = 8,
   parameter int MEM_RD_LATENCY   = 1,
   localparam int PHASE_NUM = phase_num(VIRTUAL_PORT_NUM, REAL_PORT_NUM),
   localparam int PHASE_W   = phase_w(VIRTUAL_PORT_NUM, REAL_PORT_NUM)
) (
   input  logic                                   sys_clk,
   input  logic                                   rstn,
   input  logic                                   req_valid_i,
   output logic                                   req_ready_o,
   input  logic [VIRTUAL_PORT_NUM*ADDR_WIDTH-1:0] req_addr_i,
   output logic [REAL_PORT_NUM-1:0]               mem_rd_en_o,
   output logic [REAL_PORT_NUM*ADDR_WIDTH-1:0]    mem_rd_addr_o,
   output logic                                   phase_valid_o,
   output logic [PHASE_W-1:0]                     phase_o,
   output logic                                   done_o
);

   localparam int R  = REAL_PORT_NUM;
   localparam int V  = VIRTUAL_PORT_NUM;
   localparam int AW = ADDR_WIDTH;
   localparam int SLOTS = PHASE_NUM * R;
   localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(PHASE_NUM - 1);
   localparam logic [SLOTS-1:0] EN_ALL  = '1;
   localparam logic [SLOTS-1:0] EN_MASK = EN_ALL >> (SLOTS - V);

   state_t               state, state_n;
   logic [PHASE_W-1:0]   ph, ph_n;
   logic [V*AW-1:0]      addr_q, addr_n;
   logic [SLOTS*AW-1:0]  pad;
   logic [R-1:0]         en_n;
   logic [R*AW-1:0]      rd_addr_n;
   logic                 xfer;
   lat_pl_t              pl_d, pl_q;

   assign req_ready_o = (state == ST_IDLE) ||
                        (ph == PH_LAST);
   assign xfer = req_valid_i && req_ready_o;

   // Next-state, phase counter and latched request addresses.
   always_comb begin
      state_n = state;
      ph_n    = ph;
      addr_n  = addr_q;
      unique case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_n = ST_ISSUE;
               ph_n    = '0;
               addr_n  = req_addr_i;
            end
         end
         ST_ISSUE: begin
            if (ph == PH_LAST) begin
               ph_n = '0;
               if (xfer) begin
                  addr_n = req_addr_i;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               ph_n = ph + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            ph_n    = '0;
         end
      endcase
   end

   // Pick this phase's slice; slots past V read as disabled zero.
   always_comb begin
      pad             = '0;
      pad[V*AW-1:0]   = addr_n;
      en_n            = '0;
      rd_addr_n       = '0;
      if (state_n == ST_ISSUE) begin
         en_n      = EN_MASK[int'(ph_n)*R +: R];
         rd_addr_n = pad[int'(ph_n)*R*AW +: R*AW];
      end
   end

   // Control state registers.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         ph     <= '0;
         addr_q <= '0;
      end else begin
         state  <= state_n;
         ph     <= ph_n;
         addr_q <= addr_n;
      end
   end

   // Registered memory read port outputs.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         mem_rd_en_o   <= '0;
         mem_rd_addr_o <= '0;
      end else begin
         mem_rd_en_o   <= en_n;
         mem_rd_addr_o <= rd_addr_n;
      end
   end

   // Payload for the phase being issued this cycle.
   always_comb begin
      pl_d       = '0;
      pl_d.valid = (state == ST_ISSUE);
      pl_d.last  = (state == ST_ISSUE) && (ph == PH_LAST);
      pl_d.ph    = PH_MAX_W'(ph);
   end

   memOut_lat_pipe #(
      .DEPTH (MEM_RD_LATENCY)
   ) u_lat_pipe (
      .sys_clk (sys_clk),
      .rstn    (rstn),
      .d       (pl_d),
      .q       (pl_q)
   );

   assign phase_valid_o = pl_q.valid;
   assign phase_o       = pl_q.ph[PHASE_W-1:0];
   assign done_o        = pl_q.valid && pl_q.last;

endmodule

// File: doc/memout_rd_sched.md
# memOut_rd_sched

Read scheduler that sits directly upstream of `extend_memOut_port`. It accepts one multi-port read request (VIRTUAL_PORT_NUM addresses, valid/ready handshake) and serialises it onto REAL_PORT_NUM physical memory read ports over PHASE_NUM = ceil(VIRTUAL_PORT_NUM/REAL_PORT_NUM) consecutive cycles. It tracks the memory read latency and emits phase/valid/done controls, aligned to the returning read data, so the downstream port extender can assemble `extend_port_o`.

## Interface
- REAL_PORT_NUM, 1: physical memory read ports.
- VIRTUAL_PORT_NUM, 2: logical ports per request; must be ≥ REAL_PORT_NUM.
- ADDR_WIDTH, 8: address width per port.
- MEM_RD_LATENCY, 1: cycles from `mem_rd_en_o` high to data on `real_port_i` of the extender; must be ≥ 1.
- Derived: PHASE_NUM = ceil(V/R); PHASE_W = max(1, clog2(PHASE_NUM)).

Ports:
- sys_clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  V*ADDR_WIDTH  virtual port v address in slice [v*ADDR_WIDTH +: ADDR_WIDTH].
- mem_rd_en_o  out  R  per-real-port read enable.
- mem_rd_addr_o  out  R*ADDR_WIDTH  per-real-port read address, same slicing.
- phase_valid_o  out  1  read data for `phase_o` is present at the memory output this cycle.
- phase_o  out  PHASE_W  phase index of that data.
- done_o  out  1  one-cycle pulse with the final phase of a request.

## Operation
- FSM with two states: IDLE and ISSUE. Phase counter `ph` runs 0..PHASE_NUM-1.
- Handshake: a request transfers on a rising edge where req_valid_i and req_ready_o are both 1. On transfer, req_addr_i is latched whole. The source may change req_addr_i freely after transfer.
- req_ready_o = (state==IDLE) or (state==ISSUE and ph==PHASE_NUM-1). This is combinational from registered state, so back-to-back requests need no bubble.
- During phase k, real port r serves virtual index i = k*R + r.
  - If i < V: mem_rd_en_o[r]=1 and the address is the latched address i.
  - If i ≥ V: en=0 and addr=0.
- Transitions:
  - IDLE→ISSUE on transfer, with ph=0.
  - ISSUE at the last phase: on transfer, stay in ISSUE with ph=0 and the new addresses. Otherwise go to IDLE.
  - Otherwise ph+1.
- In IDLE, mem_rd_en_o=0 and mem_rd_addr_o holds 0.
- A latency pipe of depth MEM_RD_LATENCY carries {valid, ph, last}. Its outputs drive phase_valid_o, phase_o and done_o (done_o = valid & last).
- Reset (asynchronous, any time, including mid-request):
  - state=IDLE, ph=0, pipe cleared.
  - All outputs 0 except req_ready_o=1 once state is IDLE.
  - In-flight requests are dropped; no done_o is produced for them.
- V == R: PHASE_NUM=1, PHASE_W=1 and phase_o is always 0. Every request completes in one issue cycle, and req_ready_o stays 1 continuously.

## Timing
- Let c0 be the first cycle after the transfer edge. Phase k is driven on mem_rd_en_o/mem_rd_addr_o in cycle c0+k; these are registered outputs.
- phase_valid_o=1 and phase_o=k in cycle c0+k+MEM_RD_LATENCY.
- done_o=1 in cycle c0+PHASE_NUM-1+MEM_RD_LATENCY.
- Sustained throughput is one request per PHASE_NUM cycles.

## Structure
- Package `memOut_port_pkg`:
  - `ceil_div` function.
  - PHASE_NUM/PHASE_W derivation helpers.
  - FSM state enum typedef.
  - latency-pipe payload struct typedef.
- One sub-module, `memOut_lat_pipe`: a parameterised-depth shift register of the payload struct with async active-low clear.

## Test plan
- Single request, R=1, V=2, ADDR_WIDTH=8, MEM_RD_LATENCY=1.
  - Stimulus: req_addr_i=0x2110, i.e. v0=0x10, v1=0x21.
  - Required: c0: en=1, addr=0x10. c0+1: en=1, addr=0x21. phase_valid_o in c0+1 (phase 0) and c0+2 (phase 1). done_o only in c0+2. req_ready_o=0 in c0 and 1 in c0+1.
- Back-to-back, same config: hold req_valid_i=1 with 0x2110 then 0x4333.
  - Required: addresses 0x10, 0x21, 0x33, 0x43 on four consecutive cycles.
  - Required: done_o in c0+2 and c0+4.
- Partial last phase, R=2, V=3, MEM_RD_LATENCY=2, addresses {0x03, 0x02, 0x01}.
  - Required: c0: en=2'b11, addr={0x02, 0x01}. c0+1: en=2'b01, addr={0x00, 0x03}. done_o in c0+3.
- Backpressure: req_valid_i=0 for 5 cycles after reset.
  - Required: req_ready_o=1, mem_rd_en_o=0, no phase_valid_o.
- Reset mid-request: assert rstn=0 in c0+1 of a V=2 request.
  - Required: all outputs go 0 immediately (req_ready_o=1). No done_o after release. The next request runs normally.
- V=R=2: three back-to-back requests.
  - Required: one issue cycle each, req_ready_o constantly 1, done_o on three consecutive cycles.
